// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encodings, field positions.
// No logic; constants and one pure helper function.
// Build option referenced by users of this package: CSR_COUNTERS_EN.
package csr_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Counter addresses (only decoded when CSR_COUNTERS_EN is defined)
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // csr_op encodings
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Machine interrupt codes; also the bit positions in mie/mip
    localparam int IRQ_M_SOFT  = 3;
    localparam int IRQ_M_TIMER = 7;
    localparam int IRQ_M_EXT   = 11;

    // Spread a packed {ext, timer, sw} triple onto its mie/mip bit positions
    function automatic logic [11:0] irq_expand(input logic [2:0] v);
        logic [11:0] r;
        r = '0;
        r[IRQ_M_EXT]   = v[2];
        r[IRQ_M_TIMER] = v[1];
        r[IRQ_M_SOFT]  = v[0];
        return r;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and independent low/high half write enables.
// Latency: writes and increments visible one cycle after the enabling edge.
// No backpressure; a write to either half suppresses that cycle's increment entirely.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata_lo,
    input  logic [31:0] wdata_hi,
    output logic [63:0] count
);

    // Written halves take the new data, unwritten halves hold (no carry); otherwise count up and wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wdata_lo;
            if (wr_hi) count[63:32] <= wdata_hi;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSRRW/RS/RC, trap entry/MRET state, interrupt latching, counters.
// Latency: reads and csr_illegal combinational; writes land at the next edge; irq_req two cycles after an irq line.
// No backpressure; coincident events resolve trap > mret > CSR write. Option: CSR_COUNTERS_EN adds mcycle/minstret.
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    input  logic            instret,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    output logic            irq_req,
    output logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] mepc_out
);

    localparam bit IS32 = (XLEN == 32);

    // Architectural state; mie/mip kept packed as {ext, timer, sw}
    logic            mie_bit;
    logic            mpie_bit;
    logic [2:0]      mie_q;
    logic [2:0]      mip_q;
    logic [XLEN-1:2] mtvec_base;
    logic            mtvec_vec;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:2] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic            irq_req_q;

    csr_op_e         op;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            impl;
    logic            ro;
    logic            wr_req;
    logic            wr_en;

    assign op = csr_op_e'(csr_op);

`ifdef CSR_COUNTERS_EN
    logic [63:0] cyc_cnt;
    logic [63:0] ins_cnt;
    logic        cyc_wr_lo;
    logic        cyc_wr_hi;
    logic        ins_wr_lo;
    logic        ins_wr_hi;

    // With XLEN=64 the low address covers both halves; with XLEN=32 the H addresses cover the top half
    assign cyc_wr_lo = wr_en && (csr_addr == CSR_MCYCLE);
    assign cyc_wr_hi = wr_en && (IS32 ? (csr_addr == CSR_MCYCLEH) : (csr_addr == CSR_MCYCLE));
    assign ins_wr_lo = wr_en && (csr_addr == CSR_MINSTRET);
    assign ins_wr_hi = wr_en && (IS32 ? (csr_addr == CSR_MINSTRETH) : (csr_addr == CSR_MINSTRET));

    csr_counter64 u_mcycle (
        .clk      (clk),
        .rst      (rst),
        .inc      (1'b1),
        .wr_lo    (cyc_wr_lo),
        .wr_hi    (cyc_wr_hi),
        .wdata_lo (new_val[31:0]),
        .wdata_hi (new_val[XLEN-1 -: 32]),
        .count    (cyc_cnt)
    );

    csr_counter64 u_minstret (
        .clk      (clk),
        .rst      (rst),
        .inc      (instret),
        .wr_lo    (ins_wr_lo),
        .wr_hi    (ins_wr_hi),
        .wdata_lo (new_val[31:0]),
        .wdata_hi (new_val[XLEN-1 -: 32]),
        .count    (ins_cnt)
    );
`else
    logic unused_instret;
    assign unused_instret = instret;
`endif

    // pc alignment bits and the cause bit shifted out by the vector scaling are never stored
    logic unused_bits;
    assign unused_bits = ^{trap_pc[1:0], trap_cause[XLEN-2]};

    // Address decode and read mux; unimplemented addresses read 0
    always_comb begin
        old_val = '0;
        impl    = 1'b1;
        case (csr_addr)
            CSR_MSTATUS: begin
                old_val[MSTATUS_MIE]                   = mie_bit;
                old_val[MSTATUS_MPIE]                  = mpie_bit;
                old_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            CSR_MISA:     old_val = '0;
            CSR_MIE:      old_val = XLEN'(irq_expand(mie_q));
            CSR_MTVEC:    old_val = {mtvec_base, 1'b0, mtvec_vec};
            CSR_MSCRATCH: old_val = mscratch_q;
            CSR_MEPC:     old_val = {mepc_q, 2'b00};
            CSR_MCAUSE:   old_val = mcause_q;
            CSR_MTVAL:    old_val = mtval_q;
            CSR_MIP:      old_val = XLEN'(irq_expand(mip_q));
            CSR_MHARTID:  old_val = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE, CSR_CYCLE:     old_val = cyc_cnt[XLEN-1:0];
            CSR_MINSTRET, CSR_INSTRET: old_val = ins_cnt[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH: begin
                if (IS32) old_val = XLEN'(cyc_cnt[63:32]);
                else      impl    = 1'b0;
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
                if (IS32) old_val = XLEN'(ins_cnt[63:32]);
                else      impl    = 1'b0;
            end
`endif
            default: impl = 1'b0;
        endcase
    end

    // Read-modify-write value for the addressed CSR
    always_comb begin
        new_val = old_val;
        case (op)
            CSR_OP_RW: new_val = csr_wdata;
            CSR_OP_RS: new_val = old_val | csr_wdata;
            CSR_OP_RC: new_val = old_val & ~csr_wdata;
            default:   new_val = old_val;
        endcase
    end

    // RS/RC with a zero operand are pure reads, so they are legal even on read-only CSRs
    assign ro          = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MISA) || (csr_addr == CSR_MIP);
    assign wr_req      = (op == CSR_OP_RW) || (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (csr_wdata != '0));
    assign csr_illegal = csr_valid && (!impl || (wr_req && ro));
    assign wr_en       = csr_valid && wr_req && impl && !ro && !trap_valid && !mret_valid;
    assign csr_rdata   = csr_valid ? old_val : '0;

    // Trap entry, MRET and CSR writes, in that priority order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_bit    <= 1'b0;
            mpie_bit   <= 1'b0;
            mie_q      <= '0;
            mtvec_base <= MTVEC_RESET[XLEN-1:2];
            mtvec_vec  <= 1'b0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_valid) begin
            mepc_q   <= trap_pc[XLEN-1:2];
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
            mpie_bit <= mie_bit;
            mie_bit  <= 1'b0;
        end else if (mret_valid) begin
            mie_bit  <= mpie_bit;
            mpie_bit <= 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_bit  <= new_val[MSTATUS_MIE];
                    mpie_bit <= new_val[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_q <= {new_val[IRQ_M_EXT], new_val[IRQ_M_TIMER], new_val[IRQ_M_SOFT]};
                CSR_MTVEC: begin
                    mtvec_base <= new_val[XLEN-1:2];
                    mtvec_vec  <= (new_val[1:0] == 2'b01);
                end
                CSR_MSCRATCH: mscratch_q <= new_val;
                CSR_MEPC:     mepc_q     <= new_val[XLEN-1:2];
                CSR_MCAUSE:   mcause_q   <= new_val;
                CSR_MTVAL:    mtval_q    <= new_val;
                default: ;
            endcase
        end
    end

    // Interrupt lines sampled into mip, then the enabled-pending request registered a cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mip_q     <= '0;
            irq_req_q <= 1'b0;
        end else begin
            mip_q     <= {irq_ext, irq_timer, irq_sw};
            irq_req_q <= mie_bit && |(mie_q & mip_q);
        end
    end

    // Vectored mode offsets only interrupts; exceptions always go to the base
    always_comb begin
        trap_target = {mtvec_base, 2'b00};
        if (mtvec_vec && trap_cause[XLEN-1])
            trap_target = {mtvec_base, 2'b00} + {trap_cause[XLEN-3:0], 2'b00};
    end

    assign irq_req  = irq_req_q;
    assign mepc_out = {mepc_q, 2'b00};

endmodule

// File: doc/csr_unit.md
# csr_unit

Parametrised machine-mode CSR unit for the RockWave core, the successor to the fixed eight-register CSR bank. It executes CSRRW/CSRRS/CSRRC read-modify-write operations, updates trap state on exception, interrupt and MRET, latches the interrupt lines, and keeps the 64-bit cycle and instret counters. It sits beside the execute stage and supplies the trap target PC to fetch.

## Interface
- XLEN, 32, data width; 32 or 64.
- MTVEC_RESET, 0, reset value of mtvec; bits [1:0] must be 0.
- HART_ID, 0, value returned by mhartid.
- clk  in  1  global clock
- rst  in  1  reset; asynchronous, active-high. One clock domain only.
- csr_valid  in  1  CSR instruction in execute this cycle
- csr_op  in  2  CSR operation: 00 none, 01 RW, 10 RS, 11 RC
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  rs1 value or zero-extended uimm
- csr_rdata  out  XLEN  old CSR value; combinational
- csr_illegal  out  1  illegal access; combinational
- trap_valid  in  1  take a trap this cycle
- trap_cause  in  XLEN  mcause value; MSB=1 marks an interrupt
- trap_pc  in  XLEN  PC of the trapping instruction
- trap_tval  in  XLEN  mtval value
- mret_valid  in  1  MRET retires this cycle
- instret  in  1  one instruction retires this cycle
- irq_ext, irq_timer, irq_sw  in  1 each  level-sensitive interrupt lines
- irq_req  out  1  registered: an enabled interrupt is pending
- trap_target  out  XLEN  next PC for a trap; combinational
- mepc_out  out  XLEN  current mepc, used as the MRET target

## Operation
- Implemented CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7, MPP bits 12:11), misa 0x301 (RO), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (RO), mhartid 0xF14 (RO).
- Write value by operation:
  - RW: wdata
  - RS: old | wdata
  - RC: old & ~wdata
  - RS/RC with csr_wdata==0 perform no write and are legal on RO registers.
- csr_illegal=1 when csr_valid is high and either the address is unimplemented, or the access writes a RO register (top address bits [11:10]==11, misa, or mip).
  - An illegal access changes no state.
  - csr_rdata is 0 for an unimplemented address.
- WARL field rules:
  - mepc[1:0] reads 0.
  - mtvec mode field: 00 direct, 01 vectored; writing 1x stores 00.
  - MPP always reads 11.
  - mie and mip implement bits 11, 7 and 3 only.
- Trap entry:
  - mepc <= trap_pc, mcause <= trap_cause, mtval <= trap_tval.
  - MPIE <= MIE, MIE <= 0.
- MRET: MIE <= MPIE, MPIE <= 1.
- trap_target:
  - Direct mode: mtvec base.
  - Vectored mode with an interrupt cause: base + 4*cause[XLEN-2:0].
- mip bits are registered copies of irq_ext/timer/sw (MEIP/MTIP/MSIP), one flop each.
- irq_req = registered (MIE & |(mie & mip)).

## Timing
- Reads are combinational in the csr_valid cycle. Writes take effect at the next rising edge.
- Priority when events coincide: trap_valid > mret_valid > CSR write. The losing events are dropped; the pipeline must not assert them together.
- Interrupt latency: an irq line asserted in cycle N gives mip in N+1 and irq_req in N+2.
- mstatus.MIE cleared by a trap drops irq_req on the cycle after the trap edge.
- Reset values:
  - All outputs and registers are 0, except mtvec = MTVEC_RESET and MPP = 11.
  - trap_target = MTVEC_RESET.
- Asserting rst mid-operation discards any pending write immediately.

## Configuration
- CSR_COUNTERS_EN is the single build option.
- When defined:
  - 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), plus RO aliases cycle/instret (0xC00/0xC80, 0xC02/0xC82).
  - The high-half addresses apply only when XLEN=32.
  - mcycle increments every cycle; minstret increments on instret.
  - A CSR write to a counter half wins over that cycle's increment for that half. The other half keeps its pre-increment value with no carry.
  - Counters wrap from 2^64-1 to 0.
- When undefined: these addresses are unimplemented and raise csr_illegal.

## Structure
- Shared package csr_pkg holds the CSR address constants, csr_op encodings, mstatus bit positions and the mcause interrupt codes (3, 7, 11).
- One sub-module, csr_counter64: a 64-bit counter with increment enable and separate low/high write enables. It is instantiated twice.

## Test plan
- After reset: mtvec reads MTVEC_RESET and mstatus reads 0x1800. Then RW mscratch 0xDEADBEEF, RS 0x10, RC 0x0F -> rdata returns the old values in sequence; final value 0xDEADBEF0.
- Writes to mhartid and to 0x7C0 -> csr_illegal=1 and no state change. RS mhartid with wdata 0 -> legal, rdata = HART_ID.
- mtvec=0x1001, set mie.MEIE and MIE, raise irq_ext -> irq_req two cycles later. Trap with cause 0x8000000B, pc 0x200 -> trap_target 0x102C, mepc 0x200, MIE=0, MPIE=1.
- MRET after the trap -> MIE=1, MPIE=1, mepc_out 0x200. A trap and an MRET in the same cycle -> the trap wins.
- CSR_COUNTERS_EN: write mcycle low 0xFFFFFFFF and high 0 -> the next cycle reads high 1, low 0. Pulse instret 3 times -> minstret=3.
- Assert rst in the same cycle as csr_valid with an RW write to mscratch -> mscratch remains 0.
